// File: rtl/datapath_unit.sv
// Execution datapath for the 4-bit processor: register file,
// operand latches, ALU, result/flag registers and program counter.
module datapath_unit #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int PC_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En_A,
  input  logic              En_B,
  input  logic              Wr_En,
  input  logic [1:0]        ALU_Op,
  input  logic              PC_En,
  input  logic [ADDR_W-1:0] Reg_Addr_A,
  input  logic [ADDR_W-1:0] Reg_Addr_B,
  input  logic [ADDR_W-1:0] Reg_Addr_D,
  input  logic              Ld_En,
  input  logic [DATA_W-1:0] Ld_Data,
  output logic [DATA_W-1:0] Op_A,
  output logic [DATA_W-1:0] Op_B,
  output logic [DATA_W-1:0] Result,
  output logic              Carry,
  output logic              Zero,
  output logic [PC_W-1:0]   PC,
  output logic              Done
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [DATA_W-1:0] op_a_d, op_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic [DATA_W:0]   alu;
  logic              commit;

  // A host load wins over a commit to the same port.
  assign commit = Wr_En & ~Ld_En;

  // ALU on the latched operands; top bit is carry or borrow.
  always_comb begin
    alu = '0;
    unique case (ALU_Op)
      2'd0: alu = {1'b0, op_a_q};
      2'd1: alu = {1'b0, op_a_q} + {1'b0, op_b_q};
      2'd2: alu = {1'b0, op_a_q} - {1'b0, op_b_q};
      2'd3: alu = {1'b0, op_a_q & op_b_q};
      default: alu = '0;
    endcase
  end

  // Next-state for latches, result, flags, done pulse and PC.
  always_comb begin
    op_a_d  = En_A ? rf_q[Reg_Addr_A] : op_a_q;
    op_b_d  = En_B ? rf_q[Reg_Addr_B] : op_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = commit;
    pc_d    = PC_En ? pc_q + 1'b1 : pc_q;
    if (commit) begin
      res_d   = alu[DATA_W-1:0];
      carry_d = alu[DATA_W];
      zero_d  = (alu[DATA_W-1:0] == '0);
    end
  end

  // Register file: reads see the pre-edge contents (no bypass).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (Ld_En) begin
      rf_q[Reg_Addr_D] <= Ld_Data;
    end else if (commit) begin
      rf_q[Reg_Addr_D] <= alu[DATA_W-1:0];
    end
  end

  // Datapath state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
    end
  end

  assign Op_A   = op_a_q;
  assign Op_B   = op_b_q;
  assign Result = res_q;
  assign Carry  = carry_q;
  assign Zero   = zero_q;
  assign PC     = pc_q;
  assign Done   = done_q;

endmodule
